// File: rtl/binarize_pkg.sv
// -----------------------------------------------------------------------------
// binarize_pkg
// Shared definitions for the binarization sequencer:
//   - default image geometry (IMG_W_DEF x IMG_H_DEF) and WAIT_THR timeout
//   - controller state encoding (bin_state_e)
//   - addr_w_f(): address width for a given pixel count, clog2 with a floor of 1
// No ports (package).
// -----------------------------------------------------------------------------
package binarize_pkg;

   localparam int unsigned IMG_W_DEF   = 32'd256;
   localparam int unsigned IMG_H_DEF   = 32'd256;
   localparam int unsigned TIMEOUT_DEF = 32'd1024;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SCAN_RD  = 3'd1,
      WAIT_THR = 3'd2,
      SCAN_WR  = 3'd3,
      FINISH   = 3'd4
   } bin_state_e;

   // A single-pixel image still needs a one-bit address bus.
   function automatic int unsigned addr_w_f(input int unsigned npix);
      if (npix <= 32'd2) begin
         return 32'd1;
      end else begin
         return $clog2(npix);
      end
   endfunction

endpackage

// File: rtl/pix_addr_cnt.sv
// -----------------------------------------------------------------------------
// pix_addr_cnt
// Pixel address counter for one scan pass over the image.
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (addr -> 0)
//   clear    in   force addr to 0 (has priority over advance)
//   advance  in   step addr by one; wraps to 0 after the last pixel
//   addr     out  current pixel address (registered)
//   last     out  addr is the final pixel (NPIX-1)
// -----------------------------------------------------------------------------
module pix_addr_cnt
   import binarize_pkg::*;
#(
   parameter int unsigned NPIX   = 32'd16,
   parameter int unsigned ADDR_W = 32'd4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 32'd1);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   // Next address: clear wins, otherwise step with wrap at the last pixel.
   always_comb begin
      addr_d = addr_q;
      if (clear) begin
         addr_d = '0;
      end else if (advance) begin
         if (addr_q == LAST_ADDR) begin
            addr_d = '0;
         end else begin
            addr_d = addr_q + ADDR_W'(1'b1);
         end
      end else begin
         addr_d = addr_q;
      end
   end

   // Address register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;
   assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/binarize_seq_ctrl.sv
// -----------------------------------------------------------------------------
// binarize_seq_ctrl
// Sequencer for one image binarization job: a read pass over all pixels,
// a wait for the threshold, then a write pass through the binarized path.
//
// Optional feature macro: BIN_CTRL_TIMEOUT_EN
//   defined   -> WAIT_THR gives up after TIMEOUT cycles, sets err, pulses done
//   undefined -> no timeout counter, err tied to 0, WAIT_THR waits forever
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a job (only looked at in IDLE)
//   pix_ready  in   pixel path accepts the current address this cycle
//   thr_valid  in   threshold valid (only looked at in WAIT_THR)
//   addr       out  current pixel address
//   rd_en      out  image memory read strobe (both scan passes)
//   we         out  output memory write enable (write pass, per accepted pixel)
//   enable     out  select binarized path in the output mux
//   busy       out  high whenever not IDLE
//   done       out  one-cycle completion pulse
//   err        out  WAIT_THR timeout flag
// -----------------------------------------------------------------------------
module binarize_seq_ctrl
   import binarize_pkg::*;
#(
   parameter  int unsigned IMG_W   = IMG_W_DEF,
   parameter  int unsigned IMG_H   = IMG_H_DEF,
   parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
   localparam int unsigned NPIX    = IMG_W * IMG_H,
   localparam int unsigned ADDR_W  = addr_w_f(IMG_W * IMG_H)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              pix_ready,
   input  logic              thr_valid,
   output logic [ADDR_W-1:0] addr,
   output logic              rd_en,
   output logic              we,
   output logic              enable,
   output logic              busy,
   output logic              done,
   output logic              err
);

   bin_state_e state_q;
   bin_state_e state_d;

   logic rd_en_q,    rd_en_d;
   logic wr_phase_q, wr_phase_d;
   logic enable_q,   enable_d;
   logic busy_q,     busy_d;
   logic done_q,     done_d;

   logic cnt_clear_s;
   logic cnt_adv_s;
   logic addr_last_s;
   logic tmo_hit_s;

   pix_addr_cnt #(
      .NPIX   (NPIX),
      .ADDR_W (ADDR_W)
   ) u_addr_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear_s),
      .advance (cnt_adv_s),
      .addr    (addr),
      .last    (addr_last_s)
   );

`ifdef BIN_CTRL_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic [TMO_W-1:0] tmo_cnt_d;
   logic             err_q;
   logic             err_d;

   // Count consecutive WAIT_THR cycles without a threshold; restart elsewhere.
   always_comb begin
      tmo_cnt_d = '0;
      if ((state_q == WAIT_THR) && !thr_valid && !tmo_hit_s) begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1'b1);
      end else begin
         tmo_cnt_d = '0;
      end
   end

   assign tmo_hit_s = (tmo_cnt_q == TMO_LAST);

   // err is sticky until the next accepted start.
   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         err_d = 1'b0;
      end else if ((state_q == WAIT_THR) && !thr_valid && tmo_hit_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Timeout counter and error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;

   assign tmo_hit_s = 1'b0;
   assign err       = 1'b0;
`endif

   // Next-state logic; registered outputs are then derived from the next state
   // so they line up with the state they describe.
   always_comb begin
      state_d     = state_q;
      enable_d    = enable_q;
      cnt_clear_s = 1'b0;
      cnt_adv_s   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SCAN_RD;
               cnt_clear_s = 1'b1;
               enable_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SCAN_RD: begin
            cnt_adv_s = pix_ready;
            // The counter wraps to 0 on the last accepted pixel.
            if (pix_ready && addr_last_s) begin
               state_d = WAIT_THR;
            end else begin
               state_d = SCAN_RD;
            end
         end
         WAIT_THR: begin
            if (thr_valid) begin
               state_d  = SCAN_WR;
               enable_d = 1'b1;
            end else if (tmo_hit_s) begin
               state_d = FINISH;
            end else begin
               state_d = WAIT_THR;
            end
         end
         SCAN_WR: begin
            cnt_adv_s = pix_ready;
            if (pix_ready && addr_last_s) begin
               state_d = FINISH;
            end else begin
               state_d = SCAN_WR;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            cnt_clear_s = 1'b1;
         end
      endcase

      rd_en_d    = (state_d == SCAN_RD) || (state_d == SCAN_WR);
      wr_phase_d = (state_d == SCAN_WR);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == FINISH);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_en_q    <= 1'b0;
         wr_phase_q <= 1'b0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_en_q    <= rd_en_d;
         wr_phase_q <= wr_phase_d;
         enable_q   <= enable_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rd_en  = rd_en_q;
   // Writes follow the pixel handshake so exactly one write lands per address;
   // the registered write-phase flag qualifies the live pix_ready.
   assign we     = wr_phase_q & pix_ready;
   assign enable = enable_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_binarize_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_binarize_seq_ctrl
// Directed bench for binarize_seq_ctrl with a 4x4 image (16 pixels) and
// TIMEOUT=8. Inputs change 1 time unit after the rising edge, outputs are
// sampled 2 units later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_binarize_seq_ctrl;

   localparam int unsigned W   = 32'd4;
   localparam int unsigned H   = 32'd4;
   localparam int unsigned N   = 32'd16;
   localparam int unsigned TMO = 32'd8;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       start     = 1'b0;
   logic       pix_ready = 1'b0;
   logic       thr_valid = 1'b0;
   logic [3:0] addr;
   logic       rd_en;
   logic       we;
   logic       enable;
   logic       busy;
   logic       done;
   logic       err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   binarize_seq_ctrl #(
      .IMG_W   (W),
      .IMG_H   (H),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .pix_ready (pix_ready),
      .thr_valid (thr_valid),
      .addr      (addr),
      .rd_en     (rd_en),
      .we        (we),
      .enable    (enable),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int e_addr, input logic e_rd,
                            input logic e_we, input logic e_en, input logic e_busy,
                            input logic e_done, input logic e_err);
      check({tag, ".addr"},   {28'd0, addr}, e_addr);
      check({tag, ".rd_en"},  {31'd0, rd_en}, {31'd0, e_rd});
      check({tag, ".we"},     {31'd0, we},    {31'd0, e_we});
      check({tag, ".enable"}, {31'd0, enable}, {31'd0, e_en});
      check({tag, ".busy"},   {31'd0, busy},  {31'd0, e_busy});
      check({tag, ".done"},   {31'd0, done},  {31'd0, e_done});
      check({tag, ".err"},    {31'd0, err},   {31'd0, e_err});
   endtask

   task automatic drv(input logic pr, input logic tv, input logic st);
      pix_ready = pr;
      thr_valid = tv;
      start     = st;
      #2;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Start a job and run a full-speed read pass.
   task automatic start_and_read(input string tag, input logic en_before);
      drv(1'b0, 1'b0, 1'b1);
      check_all({tag, ".idle"}, 0, 1'b0, 1'b0, en_before, 1'b0, 1'b0, 1'b0);
      adv();
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all({tag, ".rd"}, i, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
   endtask

   initial begin
      int exp_a;
      int writes;
      int c;
      logic pr;
      logic [15:0] seen;

      // ---------------- reset state, before and across a clock edge
      #3;
      check_all("rst0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_all("rst1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      adv();

      // ---------------- T1: nominal job, thr_valid after 3 WAIT_THR cycles
      start_and_read("t1", 1'b0);
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t1.wait", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b1, 1'b0);
      check_all("t1.wait_tv", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      adv();
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t1.wr", i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b0, 1'b0);
      check_all("t1.fin", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      adv();
      drv(1'b0, 1'b0, 1'b0);
      check_all("t1.end", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();

      // ---------------- T2: pix_ready toggling in both passes
      drv(1'b0, 1'b0, 1'b1);
      check_all("t2.idle", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();
      exp_a = 0;
      c = 0;
      while (exp_a < 16 && c < 64) begin
         pr = (c % 2 == 0);
         drv(pr, 1'b0, 1'b0);
         check_all("t2.rd", exp_a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (pr) exp_a++;
         c++;
         adv();
      end
      check("t2.rd_count", exp_a, 16);
      // start cleared enable from the previous job
      drv(1'b0, 1'b1, 1'b0);
      check_all("t2.wait", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      adv();
      exp_a = 0;
      writes = 0;
      seen = 16'h0000;
      c = 0;
      while (exp_a < 16 && c < 64) begin
         pr = (c % 2 == 1);
         drv(pr, 1'b0, 1'b0);
         check_all("t2.wr", exp_a, 1'b1, pr, 1'b1, 1'b1, 1'b0, 1'b0);
         if (we === 1'b1) begin
            check("t2.no_repeat", {31'd0, seen[addr]}, 0);
            seen[addr] = 1'b1;
            writes++;
         end
         if (pr) exp_a++;
         c++;
         adv();
      end
      check("t2.writes", writes, 16);
      check("t2.coverage", {16'd0, seen}, 32'h0000_FFFF);
      drv(1'b0, 1'b0, 1'b0);
      check_all("t2.fin", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      adv();
      drv(1'b0, 1'b0, 1'b0);
      check_all("t2.end", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();

      // ---------------- T3: thr_valid during SCAN_RD ignored, start in SCAN_WR ignored
      drv(1'b0, 1'b1, 1'b1);
      adv();
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b1, 1'b0);
         check_all("t3.rd", i, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
      for (int k = 0; k < 5; k++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t3.wait", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b1, 1'b0);
      adv();
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b0, (i == 5 || i == 6));
         check_all("t3.wr", i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b0, 1'b0, 1'b0);
      check_all("t3.fin", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      adv();
      drv(1'b0, 1'b0, 1'b0);
      check_all("t3.end", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      adv();

      // ---------------- T4: reset in SCAN_WR at addr 7
      start_and_read("t4", 1'b1);
      drv(1'b1, 1'b1, 1'b0);
      adv();
      for (int i = 0; i < 7; i++) begin
         drv(1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b0, 1'b0);
      check_all("t4.pre", 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_all("t4.rst_now", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      adv();
      check_all("t4.rst_edge", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drv(1'b1, 1'b1, 1'b0);
         check_all("t4.post", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         adv();
      end

`ifdef BIN_CTRL_TIMEOUT_EN
      // ---------------- T5: timeout after 8 WAIT_THR cycles
      start_and_read("t5", 1'b0);
      for (int k = 0; k < 8; k++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t5.wait", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b0, 1'b0);
      check_all("t5.fin", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      adv();
      drv(1'b1, 1'b0, 1'b1);
      check_all("t5.idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      adv();
      drv(1'b1, 1'b0, 1'b0);
      check_all("t5.restart", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      adv();
`else
      // ---------------- T5: no timeout, WAIT_THR holds well past 8 cycles
      start_and_read("t5", 1'b0);
      for (int k = 0; k < 20; k++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t5.wait", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b1, 1'b1, 1'b0);
      adv();
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 1'b0, 1'b0);
         check_all("t5.wr", i, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         adv();
      end
      drv(1'b0, 1'b0, 1'b0);
      check_all("t5.fin", 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      adv();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
